exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage of the 16-bit, 16-register pipelined CPU. Sits between decode and memory access.
//  Evaluates one ALU operation per cycle on two decoded operands, forms the load/store request,
//  and passes the register write-back tag downstream. All outputs are registered (EX/MEM boundary).
// PARAMETERS
//  DW  16  datapath width (operands, result, memory address/data)
//  AW  4   register-file address width
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  alusel_i   in   3   operation class
//  aluop_i    in   3   operation within class
//  reg0_i     in   16  operand A (rs / base address)
//  reg1_i     in   16  operand B (rt / immediate / store data / shift amount)
//  waddr_i    in   4   destination register
//  we_i       in   1   decode requests register write
//  we_o       out  1   register write enable to MEM/WB
//  waddr_o    out  4   destination register to MEM/WB
//  wdata_o    out  16  ALU result
//  memrw_o    out  2   00 none, 01 read, 10 write, 11 never driven
//  memaddr_o  out  16  data memory address
//  memdata_o  out  16  store data
//  stallreq   out  1   pipeline stall request; combinational, tied 0 (no multi-cycle ops)
// BEHAVIOUR
//  - Result computed combinationally, captured on posedge clk; latency 1 cycle, 1 op/cycle.
//  - rst=1 at posedge: we_o=0, waddr_o=0, wdata_o=0, memrw_o=00, memaddr_o=0, memdata_o=0.
//    rst dominates any operation presented in the same cycle.
//  - Default every cycle: waddr_o<=waddr_i; we_o<=we_i; memrw_o<=00; memaddr_o<=0; memdata_o<=0.
//  - alusel 000 NOP: wdata_o<=0, we_o<=0.
//  - alusel 001 LOGIC: op000 A&B, 001 A|B, 010 A^B, 011 ~A, 100 A (move).
//  - alusel 011 ARITH (mod 2^16, no flags): 000 A+B, 001 A-B, 010 0-A, 011 A+1, 100 A-1.
//  - alusel 100 COMPARE: 000 EQ -> 0 if A==B else 1; 001 SLT -> 1 if $signed(A)<$signed(B) else 0.
//  - alusel 101 MOVE: 000 A, 001 B, 010 sign-extend B[7:0].
//  - alusel 110 SHIFT: amt = (B[3:0]==0) ? 8 : B[3:0]; 000 SLL A<<amt, 001 SRL logical,
//    010 SRA arithmetic (fill A[15]), 011 ROL rotate-left A by amt.
//  - alusel 111 MEM: 000 LOAD: memrw_o<=01, memaddr_o<=A, wdata_o<=0, we_o<=we_i;
//    001 STORE: memrw_o<=10, memaddr_o<=A, memdata_o<=B, we_o<=0, wdata_o<=0.
//  - Any undefined alusel/aluop pair (incl. alusel 010): treated as NOP (wdata_o=0, we_o=0, memrw_o=00).
//  - Operand or opcode changes mid-cycle have no effect until the next posedge.
//  - stallreq=0 always, including during reset.
// STRUCTURE
//  - Shared package cpu_pkg: ALUSEL_* and ALUOP_* localparams, MEMRW_NONE/READ/WRITE, DW, AW.
//  - One sub-module: exe_shifter (combinational; A, B[3:0], aluop -> shifted result incl. 0->8 rule).
//  - Top: combinational result/mem mux + single output register block.
// TESTING
//  - Reset: rst=1, any inputs, one posedge -> all outputs 0, stallreq=0; rst=0 next op appears after 1 clk.
//  - ARITH A=8,B=1, waddr_i=1, we_i=1: op000->9, 001->7, 010->0xFFF8, 011->9, 100->7; we_o=1, waddr_o=1.
//  - SHIFT A=0x807F: B=0 SLL->0x7F00; B=1 SRL->0x403F; B=0 SRA->0xFF80; B=4 ROL->0x07F8.
//  - COMPARE: EQ A=8,B=8->0, A=1,B=8->1; SLT A=0xFFFF,B=1->1, A=8,B=1->0.
//  - MEM: LOAD A=0x4000 -> memrw_o=01, memaddr_o=0x4000, we_o=1; STORE A=0x4001,B=0x1234 ->
//    memrw_o=10, memdata_o=0x1234, we_o=0.
//  - NOP/undefined (alusel 000, 010, 111/op101) with we_i=1 -> we_o=0, wdata_o=0, memrw_o=00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: widths, ALU select/op
// encodings, memory request codes and the EX/MEM boundary record.
package cpu_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    localparam logic [2:0] ALUSEL_NOP   = 3'b000;
    localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_ARITH = 3'b011;
    localparam logic [2:0] ALUSEL_CMP   = 3'b100;
    localparam logic [2:0] ALUSEL_MOVE  = 3'b101;
    localparam logic [2:0] ALUSEL_SHIFT = 3'b110;
    localparam logic [2:0] ALUSEL_MEM   = 3'b111;

    localparam logic [2:0] ALUOP_AND   = 3'b000;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_XOR   = 3'b010;
    localparam logic [2:0] ALUOP_NOT   = 3'b011;
    localparam logic [2:0] ALUOP_MOVA  = 3'b100;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_NEG   = 3'b010;
    localparam logic [2:0] ALUOP_INC   = 3'b011;
    localparam logic [2:0] ALUOP_DEC   = 3'b100;

    localparam logic [2:0] ALUOP_EQ    = 3'b000;
    localparam logic [2:0] ALUOP_SLT   = 3'b001;

    localparam logic [2:0] ALUOP_MA    = 3'b000;
    localparam logic [2:0] ALUOP_MB    = 3'b001;
    localparam logic [2:0] ALUOP_SEXT  = 3'b010;

    localparam logic [2:0] ALUOP_SLL   = 3'b000;
    localparam logic [2:0] ALUOP_SRL   = 3'b001;
    localparam logic [2:0] ALUOP_SRA   = 3'b010;
    localparam logic [2:0] ALUOP_ROL   = 3'b011;

    localparam logic [2:0] ALUOP_LOAD  = 3'b000;
    localparam logic [2:0] ALUOP_STORE = 3'b001;

    localparam logic [1:0] MEMRW_NONE  = 2'b00;
    localparam logic [1:0] MEMRW_READ  = 2'b01;
    localparam logic [1:0] MEMRW_WRITE = 2'b10;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [1:0]    memrw;
        logic [DW-1:0] memaddr;
        logic [DW-1:0] memdata;
    } exe_out_t;

    // A zero shift field encodes the most common byte-swap distance.
    function automatic logic [3:0] shift_amt(input logic [3:0] b);
        return (b == 4'd0) ? 4'd8 : b;
    endfunction

endpackage

// File: rtl/exe_shifter.sv
// Combinational barrel shifter for the SHIFT class (SLL/SRL/SRA/ROL).
module exe_shifter
    import cpu_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [3:0]    b_i,
    input  logic [2:0]    aluop_i,
    output logic [DW-1:0] res_o,
    output logic          valid_o
);
    logic [3:0]      amt;
    logic [2*DW-1:0] rot;

    assign amt = shift_amt(b_i);
    assign rot = {a_i, a_i} << amt;

    always_comb begin
        res_o   = '0;
        valid_o = 1'b1;
        case (aluop_i)
            ALUOP_SLL: res_o = a_i << amt;
            ALUOP_SRL: res_o = a_i >> amt;
            ALUOP_SRA: res_o = $unsigned($signed(a_i) >>> amt);
            ALUOP_ROL: res_o = rot[2*DW-1:DW];
            default:   valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: one ALU/memory operation per cycle, registered at the
// EX/MEM boundary.
module exe_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    alusel_i,
    input  logic [2:0]    aluop_i,
    input  logic [DW-1:0] reg0_i,
    input  logic [DW-1:0] reg1_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          we_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [DW-1:0] wdata_o,
    output logic [1:0]    memrw_o,
    output logic [DW-1:0] memaddr_o,
    output logic [DW-1:0] memdata_o,
    output logic          stallreq
);
    exe_out_t      out_d, out_q;
    logic [DW-1:0] shf_res;
    logic          shf_vld;
    logic          nop;

    exe_shifter u_shf (
        .a_i     (reg0_i),
        .b_i     (reg1_i[3:0]),
        .aluop_i (aluop_i),
        .res_o   (shf_res),
        .valid_o (shf_vld)
    );

    always_comb begin
        out_d       = '0;
        out_d.we    = we_i;
        out_d.waddr = waddr_i;
        nop         = 1'b0;
        case (alusel_i)
            ALUSEL_LOGIC: case (aluop_i)
                ALUOP_AND:  out_d.wdata = reg0_i & reg1_i;
                ALUOP_OR:   out_d.wdata = reg0_i | reg1_i;
                ALUOP_XOR:  out_d.wdata = reg0_i ^ reg1_i;
                ALUOP_NOT:  out_d.wdata = ~reg0_i;
                ALUOP_MOVA: out_d.wdata = reg0_i;
                default:    nop = 1'b1;
            endcase
            ALUSEL_ARITH: case (aluop_i)
                ALUOP_ADD: out_d.wdata = reg0_i + reg1_i;
                ALUOP_SUB: out_d.wdata = reg0_i - reg1_i;
                ALUOP_NEG: out_d.wdata = '0 - reg0_i;
                ALUOP_INC: out_d.wdata = reg0_i + 1'b1;
                ALUOP_DEC: out_d.wdata = reg0_i - 1'b1;
                default:   nop = 1'b1;
            endcase
            ALUSEL_CMP: case (aluop_i)
                ALUOP_EQ:  out_d.wdata = {{(DW-1){1'b0}}, reg0_i != reg1_i};
                ALUOP_SLT: out_d.wdata = {{(DW-1){1'b0}}, $signed(reg0_i) < $signed(reg1_i)};
                default:   nop = 1'b1;
            endcase
            ALUSEL_MOVE: case (aluop_i)
                ALUOP_MA:   out_d.wdata = reg0_i;
                ALUOP_MB:   out_d.wdata = reg1_i;
                ALUOP_SEXT: out_d.wdata = {{(DW-8){reg1_i[7]}}, reg1_i[7:0]};
                default:    nop = 1'b1;
            endcase
            ALUSEL_SHIFT: begin
                out_d.wdata = shf_res;
                nop         = ~shf_vld;
            end
            ALUSEL_MEM: case (aluop_i)
                ALUOP_LOAD: begin
                    out_d.memrw   = MEMRW_READ;
                    out_d.memaddr = reg0_i;
                end
                ALUOP_STORE: begin
                    out_d.memrw   = MEMRW_WRITE;
                    out_d.memaddr = reg0_i;
                    out_d.memdata = reg1_i;
                    out_d.we      = 1'b0;
                end
                default: nop = 1'b1;
            endcase
            default: nop = 1'b1;
        endcase
        // Anything undecodable retires as a bubble but keeps the tag.
        if (nop) begin
            out_d.we      = 1'b0;
            out_d.wdata   = '0;
            out_d.memrw   = MEMRW_NONE;
            out_d.memaddr = '0;
            out_d.memdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign we_o      = out_q.we;
    assign waddr_o   = out_q.waddr;
    assign wdata_o   = out_q.wdata;
    assign memrw_o   = out_q.memrw;
    assign memaddr_o = out_q.memaddr;
    assign memdata_o = out_q.memdata;
    assign stallreq  = 1'b0;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed spec vectors plus a random sweep
// checked against an independent behavioural model.
module tb_exe_stage;

    typedef struct {
        string       tag;
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  memrw;
        logic [15:0] maddr;
        logic [15:0] mdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alusel_i, aluop_i;
    logic [15:0] reg0_i, reg1_i;
    logic [3:0]  waddr_i;
    logic        we_i;
    logic        we_o;
    logic [3:0]  waddr_o;
    logic [15:0] wdata_o, memaddr_o, memdata_o;
    logic [1:0]  memrw_o;
    logic        stallreq;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];

    exe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .alusel_i  (alusel_i),
        .aluop_i   (aluop_i),
        .reg0_i    (reg0_i),
        .reg1_i    (reg1_i),
        .waddr_i   (waddr_i),
        .we_i      (we_i),
        .we_o      (we_o),
        .waddr_o   (waddr_o),
        .wdata_o   (wdata_o),
        .memrw_o   (memrw_o),
        .memaddr_o (memaddr_o),
        .memdata_o (memdata_o),
        .stallreq  (stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic we, input logic [3:0] wa,
                                input logic [15:0] wd, input logic [1:0] rw,
                                input logic [15:0] ma, input logic [15:0] md);
        exp_t e;
        e.tag = tag; e.we = we; e.waddr = wa; e.wdata = wd;
        e.memrw = rw; e.maddr = ma; e.mdata = md;
        return e;
    endfunction

    // Behavioural reference: shifts/rotates done one bit at a time.
    function automatic exp_t model(input logic [2:0] sel, input logic [2:0] op,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] wa, input logic we);
        exp_t e;
        logic [15:0] r;
        int amt;
        bit bad;
        e = mk("rnd", we, wa, 16'h0, 2'b00, 16'h0, 16'h0);
        bad = 0;
        amt = (b[3:0] == 0) ? 8 : int'(b[3:0]);
        r = a;
        case (sel)
            3'd1: case (op)
                3'd0: e.wdata = a & b;
                3'd1: e.wdata = a | b;
                3'd2: e.wdata = a ^ b;
                3'd3: e.wdata = ~a;
                3'd4: e.wdata = a;
                default: bad = 1;
            endcase
            3'd3: case (op)
                3'd0: e.wdata = 16'((int'(a) + int'(b)) % 65536);
                3'd1: e.wdata = 16'((int'(a) - int'(b) + 65536) % 65536);
                3'd2: e.wdata = 16'((65536 - int'(a)) % 65536);
                3'd3: e.wdata = 16'((int'(a) + 1) % 65536);
                3'd4: e.wdata = 16'((int'(a) + 65535) % 65536);
                default: bad = 1;
            endcase
            3'd4: case (op)
                3'd0: e.wdata = (a == b) ? 16'd0 : 16'd1;
                3'd1: e.wdata = ((a[15] && !b[15]) || (a[15] == b[15] && a < b)) ? 16'd1 : 16'd0;
                default: bad = 1;
            endcase
            3'd5: case (op)
                3'd0: e.wdata = a;
                3'd1: e.wdata = b;
                3'd2: e.wdata = b[7] ? (16'hFF00 | {8'h00, b[7:0]}) : {8'h00, b[7:0]};
                default: bad = 1;
            endcase
            3'd6: begin
                case (op)
                    3'd0: repeat (amt) r = {r[14:0], 1'b0};
                    3'd1: repeat (amt) r = {1'b0, r[15:1]};
                    3'd2: repeat (amt) r = {r[15], r[15:1]};
                    3'd3: repeat (amt) r = {r[14:0], r[15]};
                    default: bad = 1;
                endcase
                e.wdata = r;
            end
            3'd7: case (op)
                3'd0: begin e.memrw = 2'b01; e.maddr = a; end
                3'd1: begin e.memrw = 2'b10; e.maddr = a; e.mdata = b; e.we = 1'b0; end
                default: bad = 1;
            endcase
            default: bad = 1;
        endcase
        if (bad) begin
            e.we = 1'b0; e.wdata = 16'h0; e.memrw = 2'b00; e.maddr = 16'h0; e.mdata = 16'h0;
        end
        return e;
    endfunction

    task automatic drive(input logic r, input logic [2:0] sel, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] wa, input logic we);
        rst = r; alusel_i = sel; aluop_i = op;
        reg0_i = a; reg1_i = b; waddr_i = wa; we_i = we;
    endtask

    // One clock: capture at posedge, compare the oldest expectation at negedge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".we"},    32'(we_o),      32'(e.we));
            chk({e.tag, ".waddr"}, 32'(waddr_o),   32'(e.waddr));
            chk({e.tag, ".wdata"}, 32'(wdata_o),   32'(e.wdata));
            chk({e.tag, ".memrw"}, 32'(memrw_o),   32'(e.memrw));
            chk({e.tag, ".maddr"}, 32'(memaddr_o), 32'(e.maddr));
            chk({e.tag, ".mdata"}, 32'(memdata_o), 32'(e.mdata));
            chk({e.tag, ".stall"}, 32'(stallreq),  32'(0));
        end
    endtask

    task automatic op(input string tag, input logic r, input logic [2:0] sel,
                      input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] wa, input logic we, input logic xwe,
                      input logic [15:0] xwd, input logic [1:0] xrw,
                      input logic [15:0] xma, input logic [15:0] xmd);
        drive(r, sel, o, a, b, wa, we);
        exp_q.push_back(mk(tag, xwe, r ? 4'h0 : wa, xwd, xrw, xma, xmd));
        step();
    endtask

    initial begin
        logic [2:0] s, o;
        logic [15:0] a, b;
        logic [3:0] wa;
        logic w;
        int guard;

        // Reset dominates a live ARITH op presented in the same cycle.
        op("rst0",  1, 3'd3, 3'd0, 16'h0008, 16'h0001, 4'h5, 1, 0, 16'h0, 2'b00, 16'h0, 16'h0);
        op("rstST", 1, 3'd7, 3'd1, 16'h4001, 16'h1234, 4'h3, 1, 0, 16'h0, 2'b00, 16'h0, 16'h0);

        op("add", 0, 3'd3, 3'd0, 16'h0008, 16'h0001, 4'h1, 1, 1, 16'h0009, 2'b00, 16'h0, 16'h0);
        op("sub", 0, 3'd3, 3'd1, 16'h0008, 16'h0001, 4'h1, 1, 1, 16'h0007, 2'b00, 16'h0, 16'h0);
        op("neg", 0, 3'd3, 3'd2, 16'h0008, 16'h0001, 4'h1, 1, 1, 16'hFFF8, 2'b00, 16'h0, 16'h0);
        op("inc", 0, 3'd3, 3'd3, 16'h0008, 16'h0001, 4'h1, 1, 1, 16'h0009, 2'b00, 16'h0, 16'h0);
        op("dec", 0, 3'd3, 3'd4, 16'h0008, 16'h0001, 4'h1, 1, 1, 16'h0007, 2'b00, 16'h0, 16'h0);

        op("sll8", 0, 3'd6, 3'd0, 16'h807F, 16'h0000, 4'h2, 1, 1, 16'h7F00, 2'b00, 16'h0, 16'h0);
        op("srl1", 0, 3'd6, 3'd1, 16'h807F, 16'h0001, 4'h2, 1, 1, 16'h403F, 2'b00, 16'h0, 16'h0);
        op("sra8", 0, 3'd6, 3'd2, 16'h807F, 16'h0000, 4'h2, 1, 1, 16'hFF80, 2'b00, 16'h0, 16'h0);
        op("rol4", 0, 3'd6, 3'd3, 16'h807F, 16'h0004, 4'h2, 1, 1, 16'h07F8, 2'b00, 16'h0, 16'h0);

        op("eqT",  0, 3'd4, 3'd0, 16'h0008, 16'h0008, 4'h3, 1, 1, 16'h0000, 2'b00, 16'h0, 16'h0);
        op("eqF",  0, 3'd4, 3'd0, 16'h0001, 16'h0008, 4'h3, 1, 1, 16'h0001, 2'b00, 16'h0, 16'h0);
        op("sltT", 0, 3'd4, 3'd1, 16'hFFFF, 16'h0001, 4'h3, 1, 1, 16'h0001, 2'b00, 16'h0, 16'h0);
        op("sltF", 0, 3'd4, 3'd1, 16'h0008, 16'h0001, 4'h3, 1, 1, 16'h0000, 2'b00, 16'h0, 16'h0);

        op("and",  0, 3'd1, 3'd0, 16'hF0F0, 16'hFF00, 4'h4, 1, 1, 16'hF000, 2'b00, 16'h0, 16'h0);
        op("or",   0, 3'd1, 3'd1, 16'hF0F0, 16'hFF00, 4'h4, 1, 1, 16'hFFF0, 2'b00, 16'h0, 16'h0);
        op("xor",  0, 3'd1, 3'd2, 16'hF0F0, 16'hFF00, 4'h4, 1, 1, 16'h0FF0, 2'b00, 16'h0, 16'h0);
        op("not",  0, 3'd1, 3'd3, 16'hF0F0, 16'hFF00, 4'h4, 1, 1, 16'h0F0F, 2'b00, 16'h0, 16'h0);
        op("sext", 0, 3'd5, 3'd2, 16'h1111, 16'h1280, 4'h6, 1, 1, 16'hFF80, 2'b00, 16'h0, 16'h0);
        op("movb", 0, 3'd5, 3'd1, 16'h1111, 16'h1280, 4'h6, 1, 1, 16'h1280, 2'b00, 16'h0, 16'h0);

        op("load",  0, 3'd7, 3'd0, 16'h4000, 16'h5555, 4'h7, 1, 1, 16'h0, 2'b01, 16'h4000, 16'h0);
        op("store", 0, 3'd7, 3'd1, 16'h4001, 16'h1234, 4'h8, 1, 0, 16'h0, 2'b10, 16'h4001, 16'h1234);

        op("nop",   0, 3'd0, 3'd0, 16'h1234, 16'h5678, 4'h9, 1, 0, 16'h0, 2'b00, 16'h0, 16'h0);
        op("sel2",  0, 3'd2, 3'd0, 16'h1234, 16'h5678, 4'hA, 1, 0, 16'h0, 2'b00, 16'h0, 16'h0);
        op("mem5",  0, 3'd7, 3'd5, 16'h1234, 16'h5678, 4'hB, 1, 0, 16'h0, 2'b00, 16'h0, 16'h0);

        // Back-to-back random traffic: one op per cycle, compared one cycle later.
        for (int i = 0; i < 300; i++) begin
            s = 3'($urandom_range(0, 7)); o = 3'($urandom_range(0, 7));
            a = 16'($urandom); b = 16'($urandom);
            wa = 4'($urandom); w = 1'($urandom);
            drive(0, s, o, a, b, wa, w);
            exp_q.push_back(model(s, o, a, b, wa, w));
            step();
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
